// File: rtl/seeder_pkg.sv
// rtl/seeder_pkg.sv - shared widths, FSM state type and row-mirror helper for board_seeder
package seeder_pkg;

    localparam int GRID_W = 64;
    localparam int ROW_W  = 8;
    localparam int POP_W  = 7;

    typedef enum logic [2:0] {
        IDLE,
        WARM,
        SAMPLE,
        CHECK,
        HOLD
    } seed_state_t;

    // Copies columns 0..3 of every row onto columns 7..4 so the board is
    // left-right symmetric (col 7-c takes col c).
    function automatic logic [GRID_W-1:0] mirror_rows(input logic [GRID_W-1:0] w);
        logic [GRID_W-1:0] m;
        m = w;
        for (int r = 0; r < ROW_W; r++) begin
            for (int c = 0; c < ROW_W / 2; c++) begin
                m[ROW_W*r + (ROW_W-1) - c] = w[ROW_W*r + c];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/popcount64.sv
// rtl/popcount64.sv - combinational 64-bit population count (adder tree)
//   i_data  [63:0] word to count
//   o_count [6:0]  number of set bits, 0..64
module popcount64
    import seeder_pkg::*;
(
    input  logic [GRID_W-1:0] i_data,
    output logic [POP_W-1:0]  o_count
);

    logic [1:0] w_s1 [32];
    logic [2:0] w_s2 [16];
    logic [3:0] w_s3 [8];
    logic [4:0] w_s4 [4];
    logic [5:0] w_s5 [2];

    // Each level adds neighbouring pairs, widening by one bit per level.
    always_comb begin
        for (int i = 0; i < 32; i++) w_s1[i] = {1'b0, i_data[2*i]} + {1'b0, i_data[2*i+1]};
        for (int i = 0; i < 16; i++) w_s2[i] = {1'b0, w_s1[2*i]} + {1'b0, w_s1[2*i+1]};
        for (int i = 0; i < 8;  i++) w_s3[i] = {1'b0, w_s2[2*i]} + {1'b0, w_s2[2*i+1]};
        for (int i = 0; i < 4;  i++) w_s4[i] = {1'b0, w_s3[2*i]} + {1'b0, w_s3[2*i+1]};
        for (int i = 0; i < 2;  i++) w_s5[i] = {1'b0, w_s4[2*i]} + {1'b0, w_s4[2*i+1]};
        o_count = {1'b0, w_s5[0]} + {1'b0, w_s5[1]};
    end

endmodule

// File: rtl/board_seeder.sv
// rtl/board_seeder.sv - samples the free-running LFSR into a population-filtered 8x8 initial board
//   clk, reset (async, active-high)
//   start       level request; rising edge starts a seeding run (IDLE only)
//   rnd_in      64-bit LFSR word, advances every clk
//   grid_ready  engine accepts the offered board
//   grid_out    board, bit 8r+c = row r, column c
//   grid_valid  grid_out holds an offered board
//   fail        offered board is the last rejected sample (retry limit hit)
//   busy        FSM not idle
//   pop_count   population of grid_out while grid_valid, else 0
// Optional: SEEDER_MIRROR_EN makes every sampled board left-right symmetric.
module board_seeder
    import seeder_pkg::*;
#(
    parameter int WARMUP    = 8,
    parameter int MIN_POP   = 16,
    parameter int MAX_POP   = 48,
    parameter int MAX_TRIES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [GRID_W-1:0] rnd_in,
    input  logic              grid_ready,
    output logic [GRID_W-1:0] grid_out,
    output logic              grid_valid,
    output logic              fail,
    output logic              busy,
    output logic [POP_W-1:0]  pop_count
);

    localparam logic [7:0]       WARM_INIT  = 8'(WARMUP - 1);
    localparam logic [7:0]       TRIES_LAST = 8'(MAX_TRIES - 1);
    localparam logic [POP_W-1:0] MIN_P      = POP_W'(MIN_POP);
    localparam logic [POP_W-1:0] MAX_P      = POP_W'(MAX_POP);

    seed_state_t       r_state,      w_state_nxt;
    logic              r_start_d;
    logic              r_armed;
    logic [7:0]        r_wcnt,       w_wcnt_nxt;
    logic [7:0]        r_tries,      w_tries_nxt;
    logic [GRID_W-1:0] r_sample,     w_sample_nxt;
    logic [GRID_W-1:0] r_grid_out,   w_grid_out_nxt;
    logic              r_grid_valid, w_grid_valid_nxt;
    logic              r_fail,       w_fail_nxt;
    logic [POP_W-1:0]  r_pop_count,  w_pop_count_nxt;

    logic              w_edge;
    logic [GRID_W-1:0] w_sample_in;
    logic [POP_W-1:0]  w_pc;
    logic              w_in_window;

`ifdef SEEDER_MIRROR_EN
    assign w_sample_in = mirror_rows(rnd_in);
`else
    assign w_sample_in = rnd_in;
`endif

    // r_armed only sets once start has been seen low, so a request already
    // held high across reset is not mistaken for a fresh rising edge.
    assign w_edge      = start & ~r_start_d & r_armed;
    assign w_in_window = (w_pc >= MIN_P) && (w_pc <= MAX_P);

    popcount64 u_popcount (
        .i_data  (r_sample),
        .o_count (w_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_start_d    <= 1'b0;
            r_armed      <= 1'b0;
            r_wcnt       <= '0;
            r_tries      <= '0;
            r_sample     <= '0;
            r_grid_out   <= '0;
            r_grid_valid <= 1'b0;
            r_fail       <= 1'b0;
            r_pop_count  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_d    <= start;
            if (!start) r_armed <= 1'b1;
            r_wcnt       <= w_wcnt_nxt;
            r_tries      <= w_tries_nxt;
            r_sample     <= w_sample_nxt;
            r_grid_out   <= w_grid_out_nxt;
            r_grid_valid <= w_grid_valid_nxt;
            r_fail       <= w_fail_nxt;
            r_pop_count  <= w_pop_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_wcnt_nxt       = r_wcnt;
        w_tries_nxt      = r_tries;
        w_sample_nxt     = r_sample;
        w_grid_out_nxt   = r_grid_out;
        w_grid_valid_nxt = r_grid_valid;
        w_fail_nxt       = r_fail;
        w_pop_count_nxt  = r_pop_count;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_nxt = WARM;
                    w_wcnt_nxt  = WARM_INIT;
                    w_tries_nxt = '0;
                    w_fail_nxt  = 1'b0;
                end
            end
            WARM: begin
                if (r_wcnt == 8'd0) w_state_nxt = SAMPLE;
                else                w_wcnt_nxt  = r_wcnt - 8'd1;
            end
            SAMPLE: begin
                w_sample_nxt = w_sample_in;
                w_state_nxt  = CHECK;
            end
            CHECK: begin
                if (w_in_window || (r_tries == TRIES_LAST)) begin
                    // Out of retries: the last rejected sample is still offered, flagged by fail.
                    w_grid_out_nxt   = r_sample;
                    w_pop_count_nxt  = w_pc;
                    w_grid_valid_nxt = 1'b1;
                    w_fail_nxt       = ~w_in_window;
                    w_state_nxt      = HOLD;
                end else begin
                    w_tries_nxt = r_tries + 8'd1;
                    w_state_nxt = SAMPLE;
                end
            end
            HOLD: begin
                if (r_grid_valid && grid_ready) begin
                    w_grid_valid_nxt = 1'b0;
                    w_pop_count_nxt  = '0;
                    w_state_nxt      = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign grid_out   = r_grid_out;
    assign grid_valid = r_grid_valid;
    assign fail       = r_fail;
    assign pop_count  = r_pop_count;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_board_seeder.sv
// tb/tb_board_seeder.sv - directed self-checking bench for board_seeder
module tb_board_seeder;

`ifdef SEEDER_MIRROR_EN
    localparam int TB_MIN_POP = 8;
`else
    localparam int TB_MIN_POP = 16;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] rnd_in;
    logic        grid_ready;
    logic [63:0] grid_out;
    logic        grid_valid;
    logic        fail;
    logic        busy;
    logic [6:0]  pop_count;

    int n_checks = 0;
    int n_fail   = 0;

    board_seeder #(
        .WARMUP    (8),
        .MIN_POP   (TB_MIN_POP),
        .MAX_POP   (48),
        .MAX_TRIES (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rnd_in     (rnd_in),
        .grid_ready (grid_ready),
        .grid_out   (grid_out),
        .grid_valid (grid_valid),
        .fail       (fail),
        .busy       (busy),
        .pop_count  (pop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after "cycle 0", the posedge that detects the edge.
    task automatic fire_start();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {63'd0, grid_valid}, 64'd0);
        check({tag, "_busy"},  {63'd0, busy},       64'd0);
        check({tag, "_fail"},  {63'd0, fail},       64'd0);
        check({tag, "_pop"},   {57'd0, pop_count},  64'd0);
        check({tag, "_grid"},  grid_out,            64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b1;
        rnd_in     = 64'h00FF_00FF_00FF_00FF;
        grid_ready = 1'b0;

        // Reset with start held high: no run until start falls then rises.
        tick(); tick();
        check_idle_outputs("rst");
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check_idle_outputs("held_start");
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("fresh_edge_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        tick();
        reset = 1'b0;

        // Accepted first sample: valid at cycle 10, transfer sampled at cycle 14.
        rnd_in = 64'h00FF_00FF_00FF_00FF;
        fire_start();
        for (int k = 1; k <= 9; k++) tick();
        check("t2_valid_c9", {63'd0, grid_valid}, 64'd0);
        tick();
        check("t2_valid_c10", {63'd0, grid_valid}, 64'd1);
        check("t2_grid", grid_out, 64'h00FF_00FF_00FF_00FF);
        check("t2_pop", {57'd0, pop_count}, 64'd32);
        check("t2_fail", {63'd0, fail}, 64'd0);
        for (int k = 11; k <= 13; k++) tick();
        check("t2_valid_c13", {63'd0, grid_valid}, 64'd1);
        grid_ready = 1'b1;
        tick();
        grid_ready = 1'b0;
        check("t2_valid_c14", {63'd0, grid_valid}, 64'd0);
        check("t2_busy_c14", {63'd0, busy}, 64'd0);
        check("t2_pop_c14", {57'd0, pop_count}, 64'd0);
        check("t2_grid_kept", grid_out, 64'h00FF_00FF_00FF_00FF);

        // All-zero samples exhaust the retry limit: fail board at cycle 38.
        rnd_in = 64'h0;
        fire_start();
        for (int k = 1; k <= 37; k++) tick();
        check("t3_valid_c37", {63'd0, grid_valid}, 64'd0);
        tick();
        check("t3_valid_c38", {63'd0, grid_valid}, 64'd1);
        check("t3_fail", {63'd0, fail}, 64'd1);
        check("t3_grid", grid_out, 64'h0);
        check("t3_pop", {57'd0, pop_count}, 64'd0);

        // Hold with ready low; a start pulse in HOLD is ignored.
        for (int k = 0; k < 20; k++) tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("hold_valid", {63'd0, grid_valid}, 64'd1);
        check("hold_fail", {63'd0, fail}, 64'd1);
        check("hold_busy", {63'd0, busy}, 64'd1);
        check("hold_grid", grid_out, 64'h0);
        reset = 1'b1;
        #1;
        check("hold_rst_valid", {63'd0, grid_valid}, 64'd0);
        check("hold_rst_busy", {63'd0, busy}, 64'd0);
        check("hold_rst_fail", {63'd0, fail}, 64'd0);
        tick();
        reset = 1'b0;
        tick();

`ifndef SEEDER_MIRROR_EN
        // Three over-population samples then an accepted one; ready held high
        // from the start must not complete the transfer in the cycle valid rises.
        rnd_in     = 64'hFFFF_FFFF_FFFF_FFFF;
        grid_ready = 1'b1;
        fire_start();
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 13) rnd_in = 64'h0F0F_0F0F_0F0F_0F0F;
        end
        check("t4_valid_c15", {63'd0, grid_valid}, 64'd0);
        tick();
        check("t4_valid_c16", {63'd0, grid_valid}, 64'd1);
        check("t4_fail", {63'd0, fail}, 64'd0);
        check("t4_pop", {57'd0, pop_count}, 64'd32);
        check("t4_grid", grid_out, 64'h0F0F_0F0F_0F0F_0F0F);
        tick();
        check("t4_valid_c17", {63'd0, grid_valid}, 64'd0);
        check("t4_busy_c17", {63'd0, busy}, 64'd0);
        grid_ready = 1'b0;
`else
        // Mirrored low nibble fills the whole first row.
        rnd_in = 64'h0000_0000_0000_000F;
        fire_start();
        for (int k = 1; k <= 10; k++) tick();
        check("mir_valid", {63'd0, grid_valid}, 64'd1);
        check("mir_grid", grid_out, 64'h0000_0000_0000_00FF);
        check("mir_pop", {57'd0, pop_count}, 64'd8);
        check("mir_fail", {63'd0, fail}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_seeder.md
Name: board_seeder

Overview:
- Downstream consumer of the free-running 64-bit LFSR. On a user start request it advances past a warm-up window, then samples the LFSR word as an 8x8 initial board.
- Rejects boards whose live-cell population is outside a window and resamples, up to a retry limit.
- Presents the accepted board to the game engine over a valid/ready handshake.

Parameters:
- WARMUP, 8, cycles spent in WARM before first sample (legal range 1..255)
- MIN_POP, 16, minimum accepted live-cell count (0..64)
- MAX_POP, 48, maximum accepted live-cell count (MIN_POP..64)
- MAX_TRIES, 15, samples attempted before giving up (1..255)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  level request, already debounced; rising edge detected internally
- rnd_in  input  64  LFSR shift_seed output; advances every clk
- grid_ready  input  1  engine accepts board
- grid_out  output  64  board; bit 8r+c = row r, column c
- grid_valid  output  1  grid_out holds an offered board
- fail  output  1  valid board is the last rejected sample (retry limit hit)
- busy  output  1  state != IDLE
- pop_count  output  7  population of grid_out while grid_valid, else 0

Behaviour:
- Clock is clk. Reset is asynchronous and active-high, on port reset. Asserting it forces immediately: state=IDLE, grid_out=0, grid_valid=0, fail=0, busy=0, pop_count=0, start_d=0, counters=0.
- start_d registers start every cycle. Edge = start & ~start_d, evaluated in IDLE only; edges in any other state are ignored and never queued.
- IDLE: on edge -> WARM, wcnt=WARMUP-1, tries=0.
- WARM: wcnt decrements each cycle; at wcnt==0 -> SAMPLE. WARM therefore lasts exactly WARMUP cycles.
- SAMPLE: sample_q <= rnd_in (after optional mirror). -> CHECK.
- CHECK: pc = popcount(sample_q).
  - MIN_POP <= pc <= MAX_POP: grid_out<=sample_q, pop_count<=pc, grid_valid<=1, fail<=0 -> HOLD.
  - Otherwise, if tries==MAX_TRIES-1: same load but fail<=1 -> HOLD.
  - Otherwise tries++ -> SAMPLE (each retry costs 2 cycles, LFSR advances 2 steps).
- HOLD: grid_out, pop_count, fail stable while grid_valid=1. On grid_valid & grid_ready: grid_valid<=0, pop_count<=0 -> IDLE. grid_out retains last board; fail holds until the next start edge clears it.
- Best-case latency: the posedge detecting the edge enters WARM; grid_valid rises WARMUP+2 cycles later.
- Ready asserted early (before valid) has no effect. Ready in the same cycle valid rises does not complete the transfer; completion is sampled on the next edge.
- Popcount is a pure function of 64 bits, result 0..64, 7-bit unsigned compare.
- Reset mid-operation (any state, including HOLD with valid high) aborts with no board delivered.

Optional Feature:
- Macro SEEDER_MIRROR_EN.
- Defined: in SAMPLE, each row's columns 7..4 are overwritten with columns 0..3 mirrored (col 7-c = col c, c<4). Population is counted on the mirrored word. The board is left-right symmetric.
- Undefined: rnd_in is captured unmodified. No mirror logic is synthesised.

Decomposition:
- Package seeder_pkg holds:
  - GRID_W=64, ROW_W=8, POP_W=7
  - typedef enum logic [2:0] {IDLE, WARM, SAMPLE, CHECK, HOLD} seed_state_t
  - function mirror_rows(logic [63:0])
- One sub-module: popcount64 (combinational 64-bit input, 7-bit output, adder tree), instantiated once on sample_q.

Test Plan:
- Reset with start=1 held: after release, no WARM entry until start falls then rises; all outputs 0 throughout.
- rnd_in forced 64'h00FF_00FF_00FF_00FF (pc=32), edge at cycle 0 -> grid_valid at cycle 10, grid_out equal to that word, pop_count=32, fail=0. grid_ready raised at cycle 13 -> grid_valid low at cycle 14, state IDLE.
- rnd_in forced 64'h0 (pc=0) -> 15 samples rejected. grid_valid with fail=1, grid_out=0, pop_count=0 at cycle 8+2*15=38.
- rnd_in = 64'hFFFF_FFFF_FFFF_FFFF (pc=64 > MAX_POP) for the first 3 samples, then 64'h0F0F_0F0F_0F0F_0F0F (pc=32) -> accepted at 4th sample, grid_valid at cycle 16, fail=0.
- With grid_ready held low 20 cycles in HOLD, pulse start -> outputs unchanged, edge ignored. Then assert reset mid-HOLD -> grid_valid drops asynchronously, no transfer.
- SEEDER_MIRROR_EN defined, rnd_in=64'h0000_0000_0000_000F -> grid_out=64'h0000_0000_0000_00FF, pop_count=8 (with MIN_POP overridden to 8).
